gf180mcu_fd_io__bi_drv_ctrl: RTL and testbench
==============================================

# gf180mcu_fd_io__bi_drv_ctrl

Clocked core-side controller for a bidirectional pad cell: the transmit counterpart of the input-only pad path. It accepts a valid/ready stream of output bits and drives the pad cell's A/OE pins one bit per beat. Break-before-make dead cycles separate receive and drive. Between bursts it releases the pad, applies the configured pull, and returns a synchronized receive bit from the pad's Y output.

## Interface
- DEAD_CYCLES, 2, turnaround cycles with OE=0 and IE=0 before and after every drive burst; legal range 1..15
- CLK  in  1  sole clock, rising edge
- RST  in  1  synchronous, active-high reset
- TX_VALID  in  1  beat offered
- TX_READY  out  1  beat accepted when TX_VALID&TX_READY at a CLK edge
- TX_DATA  in  1  bit to drive
- TX_LAST  in  1  marks final beat of a burst
- CFG_DRV  in  2  drive strength {PDRV1,PDRV0}
- CFG_SL  in  1  slew select
- CFG_PULL  in  2  00 none, 01 pull-up, 10 pull-down, 11 none
- Y  in  1  pad cell input buffer output (asynchronous)
- RX_DATA  out  1  synchronized Y
- RX_VALID  out  1  RX_DATA meaningful
- BUSY  out  1  state != IDLE
- A, OE, IE, PU, PD, PDRV0, PDRV1, SL  out  1 each  pad cell controls, all registered

## Operation
- States: IDLE, PRE, DRIVE, POST.
- IDLE:
  - OE=0, IE=1, TX_READY=1.
  - PU/PD follow CFG_PULL.
  - CFG_DRV and CFG_SL are registered every cycle.
  - An accepted beat latches data and last, and the FSM goes to PRE.
- PRE:
  - OE=0, IE=0, PU=PD=0, TX_READY=0.
  - Dead counter runs DEAD_CYCLES-1 down to 0, then the FSM goes to DRIVE.
- DRIVE:
  - OE=1, IE=0, PU=PD=0, A=current bit.
  - TX_READY = !last_reg.
  - An accepted beat updates A and last_reg.
  - With no valid beat, A holds and OE stays 1 (stall).
  - After a last beat has been on A for one cycle, the FSM goes to POST.
- POST:
  - OE=0, IE=0, pulls off, TX_READY=0.
  - Dead count as in PRE, then the FSM goes to IDLE.
- CFG_DRV and CFG_SL are frozen outside IDLE. Changes in other states take effect on the first IDLE cycle.
- RX path:
  - Y passes through a two-flop synchronizer.
  - RX_VALID=1 only in IDLE, starting on the third IDLE cycle after entry (synchronizer flushed); 0 elsewhere.
- PU and PD are never both 1. OE and IE are never both 1.
- Reset values: OE=0, A=0, IE=1, PU=PD=0, PDRV0=PDRV1=0, SL=0, TX_READY=0 while RST=1, RX_VALID=0, BUSY=0, state IDLE, sync flops 0.
- RST mid-burst: OE=0 from the reset edge. The burst is discarded, with no POST dead time. RST beats TX_VALID in the same cycle.

## Timing
- E0 = the edge accepting the first beat in IDLE:
  - IE=0 and BUSY=1 from E0.
  - OE=1 with A=D0 from E0+DEAD_CYCLES.
- Beats accepted in DRIVE at edge E appear on A from E. Each beat occupies at least one cycle.
- Last beat on A from edge EL:
  - OE=0 at EL+1.
  - IE=1, BUSY=0 and TX_READY=1 at EL+1+DEAD_CYCLES.
  - RX_VALID=1 at EL+3+DEAD_CYCLES.
- A single-beat burst (LAST on the first beat) drives exactly one cycle.
- A back-to-back burst needs no idle gap beyond the one IDLE cycle used for acceptance.

## Structure
- Package gf180mcu_fd_io__bi_drv_pkg holds:
  - the state enum;
  - the CFG_PULL encodings PULL_NONE=2'b00, PULL_UP=2'b01, PULL_DOWN=2'b10;
  - the dead-counter width constant (4 bits).
- Sub-module gf180mcu_fd_io__sync2: two-flop synchronizer with synchronous reset, instantiated for Y.
- All pad-facing outputs come straight from flops. There is no combinational path from TX_* to the pad pins.

## Test plan
All scenarios use DEAD_CYCLES=2.
- Reset: RST high 3 cycles with TX_VALID=1 -> OE=0, IE=1, TX_READY=0, PU=PD=0, BUSY=0 throughout; TX_READY=1 on the first cycle after release.
- Single beat: TX_DATA=1, TX_LAST=1 accepted at E0 -> IE=0 at E0; OE=1, A=1 at E0+2; OE=0 at E0+3; IE=1 and TX_READY=1 at E0+5; RX_VALID=1 at E0+7.
- Burst with stall: bits 1,0,1 (last on third), TX_VALID low 2 cycles before the third -> A shows 1, then 0 for 3 cycles with OE held 1, then 1 for one cycle; OE falls the next cycle.
- Config freeze: CFG_DRV=2'b11, CFG_SL=1 applied while in DRIVE -> PDRV/SL unchanged until the first IDLE cycle, then PDRV1=PDRV0=1 and SL=1.
- Pulls: CFG_PULL=01 in IDLE -> PU=1; PU=0 from E0 through POST, and 1 again on IDLE; CFG_PULL=11 -> PU=PD=0.
- Reset mid-burst: RST asserted while OE=1 -> OE=0 at the reset edge; state IDLE on release with no POST cycles; RX_VALID=1 on the third cycle after release. Pad Y toggled in IDLE -> RX_DATA follows 2 cycles later.

Source files
------------

// File: rtl/gf180mcu_fd_io__bi_drv_pkg.sv
// Shared types and constants for the bidirectional pad drive controller.
package gf180mcu_fd_io__bi_drv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StDrive,
        StPost
    } state_e;

    localparam logic [1:0] PULL_NONE = 2'b00;
    localparam logic [1:0] PULL_UP   = 2'b01;
    localparam logic [1:0] PULL_DOWN = 2'b10;

    localparam int unsigned DEAD_CNT_W = 4;

    // Returns {pu, pd}; the 2'b11 encoding maps to no pull so both are never set.
    function automatic logic [1:0] pull_decode(input logic [1:0] cfg);
        case (cfg)
            PULL_UP:   return 2'b10;
            PULL_DOWN: return 2'b01;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/gf180mcu_fd_io__sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module gf180mcu_fd_io__sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_io__bi_drv_ctrl.sv
// Core-side controller for a bidirectional pad: streams bits onto A/OE with
// break-before-make dead time, and returns a synchronized receive bit when idle.
module gf180mcu_fd_io__bi_drv_ctrl
    import gf180mcu_fd_io__bi_drv_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       TX_DATA,
    input  logic       TX_LAST,
    input  logic [1:0] CFG_DRV,
    input  logic       CFG_SL,
    input  logic [1:0] CFG_PULL,
    input  logic       Y,
    output logic       RX_DATA,
    output logic       RX_VALID,
    output logic       BUSY,
    output logic       A,
    output logic       OE,
    output logic       IE,
    output logic       PU,
    output logic       PD,
    output logic       PDRV0,
    output logic       PDRV1,
    output logic       SL
);

    localparam logic [DEAD_CNT_W-1:0] DEAD_LOAD = DEAD_CNT_W'(DEAD_CYCLES - 1);

    state_e                state;
    logic [DEAD_CNT_W-1:0] dead_cnt;
    logic                  data_reg;
    logic                  last_reg;
    // Cycles spent in IDLE since entry: 1 on entry, 0 out of reset, saturates at 3.
    logic [1:0]            idle_age;

    gf180mcu_fd_io__sync2 u_sync_y (
        .clk (CLK),
        .rst (RST),
        .d   (Y),
        .q   (RX_DATA)
    );

    assign BUSY     = (state != StIdle);
    assign TX_READY = !RST && ((state == StIdle) || ((state == StDrive) && !last_reg));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= StIdle;
            dead_cnt      <= '0;
            data_reg      <= 1'b0;
            last_reg      <= 1'b0;
            idle_age      <= 2'd0;
            RX_VALID      <= 1'b0;
            A             <= 1'b0;
            OE            <= 1'b0;
            IE            <= 1'b1;
            {PU, PD}      <= 2'b00;
            {PDRV1, PDRV0} <= 2'b00;
            SL            <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    {PDRV1, PDRV0} <= CFG_DRV;
                    SL             <= CFG_SL;
                    if (TX_VALID) begin
                        state    <= StPre;
                        dead_cnt <= DEAD_LOAD;
                        data_reg <= TX_DATA;
                        last_reg <= TX_LAST;
                        IE       <= 1'b0;
                        {PU, PD} <= 2'b00;
                        RX_VALID <= 1'b0;
                    end else begin
                        {PU, PD} <= pull_decode(CFG_PULL);
                        if (idle_age != 2'd3) idle_age <= idle_age + 2'd1;
                        RX_VALID <= (idle_age >= 2'd2);
                    end
                end
                StPre: begin
                    if (dead_cnt == '0) begin
                        state <= StDrive;
                        OE    <= 1'b1;
                        A     <= data_reg;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                StDrive: begin
                    // The last beat has already had its cycle on A.
                    if (last_reg) begin
                        state    <= StPost;
                        OE       <= 1'b0;
                        dead_cnt <= DEAD_LOAD;
                    end else if (TX_VALID) begin
                        A        <= TX_DATA;
                        last_reg <= TX_LAST;
                    end
                end
                StPost: begin
                    if (dead_cnt == '0) begin
                        state          <= StIdle;
                        IE             <= 1'b1;
                        {PU, PD}       <= pull_decode(CFG_PULL);
                        {PDRV1, PDRV0} <= CFG_DRV;
                        SL             <= CFG_SL;
                        idle_age       <= 2'd1;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_io__bi_drv_ctrl.sv
// Bench for gf180mcu_fd_io__bi_drv_ctrl: per-scenario tasks plus a scoreboard of driven bits.
module tb_gf180mcu_fd_io__bi_drv_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TX_VALID = 1'b0;
    logic       TX_DATA = 1'b0;
    logic       TX_LAST = 1'b0;
    logic [1:0] CFG_DRV = 2'b00;
    logic       CFG_SL = 1'b0;
    logic [1:0] CFG_PULL = 2'b00;
    logic       Y = 1'b0;
    logic       TX_READY, RX_DATA, RX_VALID, BUSY;
    logic       A, OE, IE, PU, PD, PDRV0, PDRV1, SL;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];
    bit exp_bit;

    gf180mcu_fd_io__bi_drv_ctrl #(.DEAD_CYCLES(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .TX_DATA  (TX_DATA),
        .TX_LAST  (TX_LAST),
        .CFG_DRV  (CFG_DRV),
        .CFG_SL   (CFG_SL),
        .CFG_PULL (CFG_PULL),
        .Y        (Y),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .BUSY     (BUSY),
        .A        (A),
        .OE       (OE),
        .IE       (IE),
        .PU       (PU),
        .PD       (PD),
        .PDRV0    (PDRV0),
        .PDRV1    (PDRV1),
        .SL       (SL)
    );

    always #5 CLK = ~CLK;

    // Every cycle with OE=1 must show the next expected bit on A.
    always @(negedge CLK) begin
        if (OE === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL drive_unexpected: A=%b driven with no bit pending", A);
            end else begin
                exp_bit = exp_q.pop_front();
                if (A !== exp_bit) begin
                    n_bad++;
                    $display("FAIL drive_bit: A=%b want %b at %0t", A, exp_bit, $time);
                end
            end
            if (IE !== 1'b0) begin
                n_bad++;
                $display("FAIL oe_ie_overlap: IE=%b want 0 while OE=1", IE);
            end
        end
    end

    task automatic settle();
        for (int i = 0; i < 20; i++) begin
            if (RX_VALID === 1'b1 && BUSY === 1'b0) return;
            @(negedge CLK);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL settle_timeout: RX_VALID=%b BUSY=%b want 1/0", RX_VALID, BUSY);
    endtask

    task automatic test_reset();
        RST = 1'b1; TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({OE, IE, TX_READY, PU, PD, BUSY} !== 6'b010000) begin
                n_bad++;
                $display("FAIL reset_hold{OE,IE,RDY,PU,PD,BUSY}: got %b want 010000",
                         {OE, IE, TX_READY, PU, PD, BUSY});
            end
        end
        RST = 1'b0; TX_VALID = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({TX_READY, IE, BUSY, RX_VALID, PDRV1, PDRV0, SL} !== 7'b1100000) begin
            n_bad++;
            $display("FAIL reset_release{RDY,IE,BUSY,RXV,PDRV,SL}: got %b want 1100000",
                     {TX_READY, IE, BUSY, RX_VALID, PDRV1, PDRV0, SL});
        end
        @(negedge CLK);
        n_cmp++;
        if (RX_VALID !== 1'b0) begin
            n_bad++; $display("FAIL reset_rxv_early: got %b want 0", RX_VALID);
        end
        @(negedge CLK);
        n_cmp++;
        if (RX_VALID !== 1'b1) begin
            n_bad++; $display("FAIL reset_rxv_third: got %b want 1", RX_VALID);
        end
    endtask

    task automatic test_single_beat();
        TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge CLK);  // E0
        TX_VALID = 1'b0;
        n_cmp++;
        if ({IE, BUSY, OE, TX_READY} !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_e0{IE,BUSY,OE,RDY}: got %b want 0100", {IE, BUSY, OE, TX_READY});
        end
        @(negedge CLK);
        n_cmp++;
        if (OE !== 1'b0) begin n_bad++; $display("FAIL single_e1_oe: got %b want 0", OE); end
        @(negedge CLK);
        n_cmp++;
        if ({OE, A} !== 2'b11) begin
            n_bad++; $display("FAIL single_e2{OE,A}: got %b want 11", {OE, A});
        end
        @(negedge CLK);
        n_cmp++;
        if (OE !== 1'b0) begin n_bad++; $display("FAIL single_e3_oe: got %b want 0", OE); end
        @(negedge CLK);
        n_cmp++;
        if ({IE, BUSY} !== 2'b01) begin
            n_bad++; $display("FAIL single_e4{IE,BUSY}: got %b want 01", {IE, BUSY});
        end
        @(negedge CLK);
        n_cmp++;
        if ({IE, TX_READY, BUSY, RX_VALID} !== 4'b1100) begin
            n_bad++;
            $display("FAIL single_e5{IE,RDY,BUSY,RXV}: got %b want 1100",
                     {IE, TX_READY, BUSY, RX_VALID});
        end
        @(negedge CLK);
        n_cmp++;
        if (RX_VALID !== 1'b0) begin n_bad++; $display("FAIL single_e6_rxv: got %b want 0", RX_VALID); end
        @(negedge CLK);
        n_cmp++;
        if (RX_VALID !== 1'b1) begin n_bad++; $display("FAIL single_e7_rxv: got %b want 1", RX_VALID); end
    endtask

    task automatic test_stall();
        TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b0;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        @(negedge CLK);  // E0
        TX_DATA = 1'b0;
        @(negedge CLK);
        @(negedge CLK);  // E0+2
        n_cmp++;
        if ({OE, A, TX_READY} !== 3'b111) begin
            n_bad++; $display("FAIL stall_first{OE,A,RDY}: got %b want 111", {OE, A, TX_READY});
        end
        @(negedge CLK);  // E0+3, second beat on A
        TX_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);  // E0+5
        n_cmp++;
        if ({OE, A} !== 2'b10) begin
            n_bad++; $display("FAIL stall_hold{OE,A}: got %b want 10", {OE, A});
        end
        TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b1;
        @(negedge CLK);  // E0+6
        TX_VALID = 1'b0;
        n_cmp++;
        if ({OE, A, TX_READY} !== 3'b110) begin
            n_bad++; $display("FAIL stall_last{OE,A,RDY}: got %b want 110", {OE, A, TX_READY});
        end
        @(negedge CLK);
        n_cmp++;
        if ({OE, BUSY} !== 2'b01) begin
            n_bad++; $display("FAIL stall_post{OE,BUSY}: got %b want 01", {OE, BUSY});
        end
    endtask

    task automatic test_cfg_freeze();
        n_cmp++;
        if ({PDRV1, PDRV0, SL} !== 3'b000) begin
            n_bad++; $display("FAIL cfg_start: got %b want 000", {PDRV1, PDRV0, SL});
        end
        TX_VALID = 1'b1; TX_DATA = 1'b0; TX_LAST = 1'b1;
        exp_q.push_back(1'b0);
        @(negedge CLK);
        TX_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);  // E0+2, in DRIVE
        CFG_DRV = 2'b11; CFG_SL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({PDRV1, PDRV0, SL} !== 3'b000) begin
                n_bad++; $display("FAIL cfg_frozen: got %b want 000", {PDRV1, PDRV0, SL});
            end
        end
        @(negedge CLK);  // E0+5, first IDLE cycle
        n_cmp++;
        if ({IE, PDRV1, PDRV0, SL} !== 4'b1111) begin
            n_bad++; $display("FAIL cfg_idle{IE,PDRV,SL}: got %b want 1111", {IE, PDRV1, PDRV0, SL});
        end
        CFG_DRV = 2'b00; CFG_SL = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({PDRV1, PDRV0, SL} !== 3'b000) begin
            n_bad++; $display("FAIL cfg_idle_track: got %b want 000", {PDRV1, PDRV0, SL});
        end
    endtask

    task automatic test_pulls();
        CFG_PULL = 2'b01;
        @(negedge CLK);
        n_cmp++;
        if ({PU, PD} !== 2'b10) begin n_bad++; $display("FAIL pull_up_idle: got %b want 10", {PU, PD}); end
        TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b1;
        exp_q.push_back(1'b1);
        @(negedge CLK);  // E0
        TX_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({PU, PD} !== 2'b00) begin
                n_bad++; $display("FAIL pull_busy_%0d: got %b want 00", i, {PU, PD});
            end
            @(negedge CLK);
        end
        n_cmp++;
        if ({PU, PD, BUSY} !== 3'b100) begin
            n_bad++; $display("FAIL pull_reidle{PU,PD,BUSY}: got %b want 100", {PU, PD, BUSY});
        end
        CFG_PULL = 2'b10;
        @(negedge CLK);
        n_cmp++;
        if ({PU, PD} !== 2'b01) begin n_bad++; $display("FAIL pull_down: got %b want 01", {PU, PD}); end
        CFG_PULL = 2'b11;
        @(negedge CLK);
        n_cmp++;
        if ({PU, PD} !== 2'b00) begin n_bad++; $display("FAIL pull_11: got %b want 00", {PU, PD}); end
        CFG_PULL = 2'b00;
    endtask

    task automatic test_back_to_back();
        TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b1;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        @(negedge CLK);  // E0
        TX_DATA = 1'b0;
        repeat (5) @(negedge CLK);  // E0+5, IDLE with second burst offered
        n_cmp++;
        if ({IE, TX_READY} !== 2'b11) begin
            n_bad++; $display("FAIL b2b_idle{IE,RDY}: got %b want 11", {IE, TX_READY});
        end
        @(negedge CLK);  // E0+6, second burst accepted
        TX_VALID = 1'b0;
        n_cmp++;
        if ({IE, BUSY} !== 2'b01) begin
            n_bad++; $display("FAIL b2b_accept{IE,BUSY}: got %b want 01", {IE, BUSY});
        end
        @(negedge CLK);
        @(negedge CLK);  // E0+8
        n_cmp++;
        if ({OE, A} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_drive{OE,A}: got %b want 10", {OE, A});
        end
        @(negedge CLK);
        n_cmp++;
        if (OE !== 1'b0) begin n_bad++; $display("FAIL b2b_post_oe: got %b want 0", OE); end
    endtask

    task automatic test_reset_mid_burst();
        TX_VALID = 1'b1; TX_DATA = 1'b1; TX_LAST = 1'b0;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        repeat (4) @(negedge CLK);  // E0+3, second beat on A
        n_cmp++;
        if (OE !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_oe: got %b want 1", OE); end
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({OE, IE, BUSY, TX_READY} !== 4'b0100) begin
            n_bad++;
            $display("FAIL midrst_edge{OE,IE,BUSY,RDY}: got %b want 0100", {OE, IE, BUSY, TX_READY});
        end
        RST = 1'b0; TX_VALID = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({OE, IE, BUSY, TX_READY, RX_VALID} !== 5'b01010) begin
            n_bad++;
            $display("FAIL midrst_release{OE,IE,BUSY,RDY,RXV}: got %b want 01010",
                     {OE, IE, BUSY, TX_READY, RX_VALID});
        end
        @(negedge CLK);
        n_cmp++;
        if (RX_VALID !== 1'b0) begin n_bad++; $display("FAIL midrst_rxv2: got %b want 0", RX_VALID); end
        @(negedge CLK);
        n_cmp++;
        if (RX_VALID !== 1'b1) begin n_bad++; $display("FAIL midrst_rxv3: got %b want 1", RX_VALID); end
        Y = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (RX_DATA !== 1'b0) begin n_bad++; $display("FAIL rx_rise_early: got %b want 0", RX_DATA); end
        @(negedge CLK);
        n_cmp++;
        if (RX_DATA !== 1'b1) begin n_bad++; $display("FAIL rx_rise: got %b want 1", RX_DATA); end
        Y = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (RX_DATA !== 1'b1) begin n_bad++; $display("FAIL rx_fall_early: got %b want 1", RX_DATA); end
        @(negedge CLK);
        n_cmp++;
        if (RX_DATA !== 1'b0) begin n_bad++; $display("FAIL rx_fall: got %b want 0", RX_DATA); end
    endtask

    initial begin
        test_reset();
        settle();
        test_single_beat();
        settle();
        test_stall();
        settle();
        test_cfg_freeze();
        settle();
        test_pulls();
        settle();
        test_back_to_back();
        settle();
        test_reset_mid_burst();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d bits never driven, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
